// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port SRAM between the instruction-fetch and data ports.
// The data port has priority. A starvation counter lets fetch win the contested cycle after it has waited STARVE_MAX cycles.
module mem_port_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                dm_req,
    input  logic [DATA_W/8-1:0] dm_web,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    output logic                dm_gnt,
    output logic                dm_rvalid,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                sram_cs,
    output logic                sram_oe,
    output logic [DATA_W/8-1:0] sram_web,
    output logic [ADDR_W-1:0]   sram_a,
    output logic [DATA_W-1:0]   sram_di,
    input  logic [DATA_W-1:0]   sram_do
);

    localparam int                 LANES      = DATA_W / 8;
    localparam logic [3:0]         STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [LANES-1:0]   WEB_READ   = {LANES{1'b1}};

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_e;

    logic [3:0]        starve_cnt_q, starve_cnt_d;
    owner_e            resp_owner_q, resp_owner_d;
    logic [ADDR_W-1:0] sram_a_q, sram_a_d;
    logic [DATA_W-1:0] sram_di_q, sram_di_d;
    logic              starved;
    logic              dm_is_read;

    assign starved    = (starve_cnt_q == STARVE_LIM);
    assign dm_is_read = (dm_web == WEB_READ);

    // Grant selection; requests are ignored while reset is asserted
    always_comb begin
        if_gnt = 1'b0;
        dm_gnt = 1'b0;
        if (rst) begin
            if_gnt = 1'b0;
            dm_gnt = 1'b0;
        end else if (if_req && (!dm_req || starved)) begin
            if_gnt = 1'b1;
        end else if (dm_req) begin
            dm_gnt = 1'b1;
        end else begin
            if_gnt = 1'b0;
            dm_gnt = 1'b0;
        end
    end

    // Next-state: starvation count, response owner, held SRAM address/data
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        resp_owner_d = OWN_NONE;
        sram_a_d     = sram_a_q;
        sram_di_d    = sram_di_q;

        if (!if_req || if_gnt) begin
            starve_cnt_d = 4'd0;
        end else if (starve_cnt_q < STARVE_LIM) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end else begin
            starve_cnt_d = starve_cnt_q;
        end

        if (if_gnt) begin
            resp_owner_d = OWN_IF;
            sram_a_d     = if_addr;
        end else if (dm_gnt) begin
            resp_owner_d = dm_is_read ? OWN_DM : OWN_NONE;
            sram_a_d     = dm_addr;
            sram_di_d    = dm_wdata;
        end else begin
            resp_owner_d = OWN_NONE;
        end
    end

    // SRAM pin drive; address and write data keep their last value when idle
    always_comb begin
        sram_cs  = 1'b0;
        sram_oe  = 1'b0;
        sram_web = WEB_READ;
        sram_a   = sram_a_d;
        sram_di  = sram_di_d;
        if (if_gnt) begin
            sram_cs = 1'b1;
            sram_oe = 1'b1;
        end else if (dm_gnt) begin
            sram_cs  = 1'b1;
            sram_oe  = dm_is_read;
            sram_web = dm_web;
        end else begin
            sram_cs = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_q <= 4'd0;
            resp_owner_q <= OWN_NONE;
            sram_a_q     <= {ADDR_W{1'b0}};
            sram_di_q    <= {DATA_W{1'b0}};
        end else begin
            starve_cnt_q <= starve_cnt_d;
            resp_owner_q <= resp_owner_d;
            sram_a_q     <= sram_a_d;
            sram_di_q    <= sram_di_d;
        end
    end

    // Read data goes unqualified to both ports; rvalid tells the consumer which one owns it
    assign if_rvalid = (resp_owner_q == OWN_IF);
    assign dm_rvalid = (resp_owner_q == OWN_DM);
    assign if_rdata  = rst ? {DATA_W{1'b0}} : sram_do;
    assign dm_rdata  = rst ? {DATA_W{1'b0}} : sram_do;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter.
// Expected values come from a priority/starvation reference model and a shadow memory.
module tb_mem_port_arbiter;

    localparam int SMAX = 3;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [13:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic [3:0]  dm_web;
    logic [13:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt, dm_rvalid;
    logic [31:0] dm_rdata;
    logic        sram_cs, sram_oe;
    logic [3:0]  sram_web;
    logic [13:0] sram_a;
    logic [31:0] sram_di;
    logic [31:0] sram_do = 32'h0;

    mem_port_arbiter #(.ADDR_W(14), .DATA_W(32), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_web(dm_web), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_web(sram_web),
        .sram_a(sram_a), .sram_di(sram_di), .sram_do(sram_do)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] sram_mem [0:16383];
    logic [31:0] ref_mem  [0:16383];

    // Behavioural SRAM: read data appears the cycle after the access
    always @(posedge clk) begin
        if (sram_cs) begin
            if (sram_web == 4'hF) begin
                sram_do <= sram_mem[sram_a];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (!sram_web[b]) sram_mem[sram_a][8*b +: 8] <= sram_di[8*b +: 8];
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int          m_starve;
    int          m_owner;      // 0 none, 1 fetch, 2 data
    logic [31:0] m_rdata;
    logic [13:0] m_last_a;
    logic [31:0] m_last_di;
    logic        m_if_g, m_dm_g;

    logic        obs_if_gnt, obs_dm_gnt, obs_if_rvalid, obs_dm_rvalid, obs_cs, obs_oe;
    logic [3:0]  obs_web;
    logic [13:0] obs_a;
    logic [31:0] obs_if_rdata, obs_dm_rdata;

    task automatic model_reset();
        m_starve  = 0;
        m_owner   = 0;
        m_rdata   = 32'h0;
        m_last_a  = 14'h0;
        m_last_di = 32'h0;
    endtask

    // Called at a falling edge: drive, check, advance model, wait one cycle
    task automatic do_cycle(input logic ir, input logic [13:0] ia, input logic dr,
                            input logic [3:0] dw, input logic [13:0] da, input logic [31:0] dd);
        logic        iw, dwin, rd;
        logic [13:0] exp_a;
        logic [31:0] exp_di;
        if_req = ir; if_addr = ia; dm_req = dr; dm_web = dw; dm_addr = da; dm_wdata = dd;
        #1;
        iw     = ir && (!dr || m_starve == SMAX);
        dwin   = dr && !iw;
        rd     = iw || (dwin && dw == 4'hF);
        exp_a  = iw ? ia : (dwin ? da : m_last_a);
        exp_di = dwin ? dd : m_last_di;
        obs_if_gnt = if_gnt; obs_dm_gnt = dm_gnt; obs_cs = sram_cs; obs_oe = sram_oe;
        obs_web = sram_web; obs_a = sram_a; obs_if_rvalid = if_rvalid; obs_dm_rvalid = dm_rvalid;
        obs_if_rdata = if_rdata; obs_dm_rdata = dm_rdata;
        check_eq("if_gnt", if_gnt, iw);
        check_eq("dm_gnt", dm_gnt, dwin);
        check_eq("sram_cs", sram_cs, iw || dwin);
        check_eq("sram_oe", sram_oe, rd);
        check_eq("sram_web", sram_web, dwin ? dw : 4'hF);
        check_eq("sram_a", sram_a, exp_a);
        check_eq("sram_di", sram_di, exp_di);
        check_eq("if_rvalid", if_rvalid, m_owner == 1);
        check_eq("dm_rvalid", dm_rvalid, m_owner == 2);
        if (m_owner != 0) begin
            check_eq("if_rdata", if_rdata, m_rdata);
            check_eq("dm_rdata", dm_rdata, m_rdata);
        end
        m_owner = 0;
        if (iw) begin
            m_owner = 1;
            m_rdata = ref_mem[ia];
        end else if (dwin) begin
            if (dw == 4'hF) begin
                m_owner = 2;
                m_rdata = ref_mem[da];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (!dw[b]) ref_mem[da][8*b +: 8] = dd[8*b +: 8];
            end
        end
        m_last_a  = exp_a;
        m_last_di = exp_di;
        if (!ir || iw) m_starve = 0;
        else if (m_starve < SMAX) m_starve++;
        m_if_g = iw;
        m_dm_g = dwin;
        @(negedge clk);
    endtask

    task automatic idle_cycle();
        do_cycle(1'b0, 14'h0, 1'b0, 4'hF, 14'h0, 32'h0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic        ip, dp;
        logic [13:0] ia, da, dmn;
        logic [3:0]  dwv;
        logic [31:0] dd;

        for (int i = 0; i < 16384; i++) begin
            sram_mem[i] = 32'(i) * 32'h9E3779B1 + 32'h1234;
            ref_mem[i]  = sram_mem[i];
        end
        rst = 1'b1;
        if_req = 1'b1; if_addr = 14'h7; dm_req = 1'b1; dm_web = 4'h0; dm_addr = 14'h9; dm_wdata = 32'h55;
        sram_mem[16] = 32'hDEADBEEF;
        ref_mem[16]  = 32'hDEADBEEF;
        repeat (2) @(negedge clk);
        #1;
        // Reset state with both requests high
        check_eq("rst_if_gnt", if_gnt, 1'b0);
        check_eq("rst_dm_gnt", dm_gnt, 1'b0);
        check_eq("rst_if_rvalid", if_rvalid, 1'b0);
        check_eq("rst_dm_rvalid", dm_rvalid, 1'b0);
        check_eq("rst_cs", sram_cs, 1'b0);
        check_eq("rst_oe", sram_oe, 1'b0);
        check_eq("rst_web", sram_web, 4'hF);
        check_eq("rst_a", sram_a, 14'h0);
        check_eq("rst_di", sram_di, 32'h0);
        check_eq("rst_rdata", if_rdata | dm_rdata, 32'h0);
        if_req = 1'b0; dm_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Single fetch read
        do_cycle(1'b1, 14'h0010, 1'b0, 4'hF, 14'h0, 32'h0);
        check_eq("single_gnt", obs_if_gnt, 1'b1);
        check_eq("single_a", obs_a, 14'h0010);
        check_eq("single_oe", obs_oe, 1'b1);
        idle_cycle();
        check_eq("single_rvalid", obs_if_rvalid, 1'b1);
        check_eq("single_rdata", obs_if_rdata, 32'hDEADBEEF);
        check_eq("single_dm_rvalid", obs_dm_rvalid, 1'b0);

        // Contention with data reads: D,D,D,I repeating
        ia = 14'h20; dmn = 14'h40;
        for (int k = 0; k < 8; k++) begin
            do_cycle(1'b1, ia, 1'b1, 4'hF, dmn, 32'h0);
            check_eq("cont_pat", {obs_if_gnt, obs_dm_gnt}, (k % 4 == 3) ? 2'b10 : 2'b01);
            if (m_if_g) ia = ia + 14'h1;
            if (m_dm_g) dmn = dmn + 14'h1;
        end
        idle_cycle();

        // Byte store then load
        do_cycle(1'b0, 14'h0, 1'b1, 4'b1101, 14'h0004, 32'h0000AB00);
        check_eq("bst_web", obs_web, 4'b1101);
        check_eq("bst_oe", obs_oe, 1'b0);
        do_cycle(1'b0, 14'h0, 1'b1, 4'hF, 14'h0004, 32'h0);
        check_eq("bst_no_rvalid", obs_dm_rvalid, 1'b0);
        idle_cycle();
        check_eq("bld_rvalid", obs_dm_rvalid, 1'b1);
        check_eq("bld_byte1", obs_dm_rdata[15:8], 8'hAB);

        // Back-to-back data reads
        for (int k = 1; k <= 3; k++) begin
            do_cycle(1'b0, 14'h0, 1'b1, 4'hF, 14'(k), 32'h0);
            check_eq("b2b_gnt", obs_dm_gnt, 1'b1);
        end
        idle_cycle();
        check_eq("b2b_last_rvalid", obs_dm_rvalid, 1'b1);
        check_eq("b2b_last_data", obs_dm_rdata, ref_mem[3]);

        // Idle after a write keeps the address
        do_cycle(1'b0, 14'h0, 1'b1, 4'b0000, 14'h0123, 32'hCAFEF00D);
        repeat (5) begin
            idle_cycle();
            check_eq("idle_a", obs_a, 14'h0123);
            check_eq("idle_cs", obs_cs, 1'b0);
        end

        // Reset during a granted fetch cycle
        if_req = 1'b1; if_addr = 14'h0010; dm_req = 1'b0;
        #1;
        check_eq("rsta_pre_gnt", if_gnt, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("rsta_gnt", if_gnt, 1'b0);
        check_eq("rsta_cs", sram_cs, 1'b0);
        check_eq("rsta_web", sram_web, 4'hF);
        check_eq("rsta_a", sram_a, 14'h0);
        @(posedge clk);
        #1;
        check_eq("rsta_rvalid", if_rvalid, 1'b0);
        @(negedge clk);
        if_req = 1'b0;
        rst = 1'b0;
        model_reset();
        repeat (3) idle_cycle();
        check_eq("rsta_idle_a", obs_a, 14'h0);

        // Reset with a read response in flight
        do_cycle(1'b1, 14'h0011, 1'b0, 4'hF, 14'h0, 32'h0);
        rst = 1'b1;
        #1;
        check_eq("rstb_rvalid", if_rvalid, 1'b0);
        check_eq("rstb_rdata", if_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        idle_cycle();

        // Randomized traffic over a small address window
        ip = 1'b0; dp = 1'b0; ia = 14'h0; da = 14'h0; dwv = 4'hF; dd = 32'h0;
        for (int n = 0; n < 3000; n++) begin
            if (!ip && $urandom_range(0, 3) != 0) begin
                ip = 1'b1;
                ia = 14'($urandom_range(0, 31));
            end
            if (!dp && $urandom_range(0, 2) != 0) begin
                dp = 1'b1;
                da = 14'($urandom_range(0, 31));
                dd = $urandom;
                case ($urandom_range(0, 3))
                    0, 1:    dwv = 4'hF;
                    2:       dwv = 4'h0;
                    default: dwv = 4'($urandom_range(0, 14));
                endcase
            end
            do_cycle(ip, ia, dp, dwv, da, dd);
            if (m_if_g) ip = 1'b0;
            if (m_dm_g) dp = 1'b0;
        end
        idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
